// File: rtl/pipe_stage_reg_pkg.sv
// pipes: shared types for the generic inter-stage pipeline register.
//   pipe_occ_t    - 2-bit entry count (0..2)
//   pipe_state_t  - handshake state of one stage register
//   PIPE_CNT_W    - width of the optional performance counters
//   *_data_t      - per-stage payloads; size WIDTH with $bits() of these
package pipes;

    typedef logic [1:0] pipe_occ_t;

    localparam int PIPE_CNT_W = 32;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_BUSY  = 2'd1,
        PIPE_FULL  = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_data_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } decode_data_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } execute_data_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } memory_data_t;

    function automatic pipe_occ_t pipe_occ_of(input pipe_state_t s);
        case (s)
            PIPE_BUSY: return 2'd1;
            PIPE_FULL: return 2'd2;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg_skid_buf.sv
// pipe_skid_buf: second (skid) entry of a pipe_stage_reg plus the registered
// upstream ready, so in_ready has no combinational path from downstream.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   load            - capture in_data into the skid entry this edge
//   in_data         - upstream payload
//   ready_next      - in_ready value for the next cycle (skid free next cycle)
//   skid_data       - held skid payload
//   in_ready        - registered upstream ready
module pipe_skid_buf #(
    parameter int               WIDTH      = 64,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic             ready_next,
    output logic [WIDTH-1:0] skid_data,
    output logic             in_ready
);

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_data <= RESET_DATA;
            in_ready  <= 1'b1;
        end else begin
            in_ready <= ready_next;
            if (load) begin
                skid_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline register between core stages.
// Holds a main (head) entry and, when SKID=1, a skid entry so in_ready is a
// register. flush drops everything held and any concurrent accept.
// Optional build macro: PIPE_STAGE_PERF_EN adds stall_cnt / flush_cnt.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   flush                 - discard all held entries
//   stall                 - hazard hold, blocks delivery
//   in_valid/in_ready/in_data    - upstream handshake and payload
//   out_valid/out_ready/out_data - downstream handshake and head payload
//   occupancy             - entries held (0..2)
//   stall_cnt, flush_cnt  - (PIPE_STAGE_PERF_EN) saturating event counters
//
// state      | meaning
// PIPE_EMPTY | no entry held
// PIPE_BUSY  | main entry valid, skid empty
// PIPE_FULL  | main and skid valid (SKID=1 only)
module pipe_stage_reg
    import pipes::*;
#(
    parameter int               WIDTH      = 64,
    parameter int               SKID       = 1,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             stall,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output pipe_occ_t        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [PIPE_CNT_W-1:0] stall_cnt,
    output logic [PIPE_CNT_W-1:0] flush_cnt
`endif
);

    pipe_state_t      state_q;
    pipe_state_t      state_d;
    logic [WIDTH-1:0] main_data_q;
    logic [WIDTH-1:0] skid_data;
    logic             in_ready_reg;
    logic             accept;
    logic             deliver;
    logic             main_load;
    logic             main_from_skid;
    logic             skid_load;

    assign out_valid = (state_q != PIPE_EMPTY);
    assign out_data  = main_data_q;
    assign occupancy = pipe_occ_of(state_q);

    // Without a skid slot the head can only be refilled if it leaves this edge.
    assign in_ready = (SKID != 0) ? in_ready_reg
                                  : ((state_q == PIPE_EMPTY) | (out_ready & ~stall));

    assign accept  = in_valid & in_ready;
    assign deliver = out_valid & out_ready & ~stall;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_d = PIPE_EMPTY;
        end else begin
            case (state_q)
                PIPE_EMPTY: begin
                    if (accept) begin
                        state_d   = PIPE_BUSY;
                        main_load = 1'b1;
                    end
                end
                PIPE_BUSY: begin
                    if (accept && deliver) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        // only reachable with SKID=1; SKID=0 is not ready here
                        state_d   = PIPE_FULL;
                        skid_load = 1'b1;
                    end else if (deliver) begin
                        state_d = PIPE_EMPTY;
                    end
                end
                PIPE_FULL: begin
                    // in_ready is low here, so only the skid drain can happen
                    if (deliver) begin
                        state_d        = PIPE_BUSY;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = PIPE_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PIPE_EMPTY;
            main_data_q <= RESET_DATA;
        end else begin
            state_q <= state_d;
            if (main_load) begin
                main_data_q <= main_from_skid ? skid_data : in_data;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            pipe_skid_buf #(
                .WIDTH      (WIDTH),
                .RESET_DATA (RESET_DATA)
            ) u_skid (
                .clk        (clk),
                .reset      (reset),
                .load       (skid_load),
                .in_data    (in_data),
                .ready_next (state_d != PIPE_FULL),
                .skid_data  (skid_data),
                .in_ready   (in_ready_reg)
            );
        end else begin : g_noskid
            assign skid_data    = RESET_DATA;
            assign in_ready_reg = 1'b1;
        end
    endgenerate

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !(out_ready && !stall) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + PIPE_CNT_W'(1);
            end
            if (flush && (occupancy != 2'd0) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + PIPE_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance on shared
// stimulus, each checked against a bounded-FIFO reference model, plus a
// vector table for the SKID=1 instance and short hand-written sequences.
module tb_pipe_stage_reg;

    localparam logic [63:0] RST_D = 64'hDEAD;

    logic        clk = 1'b0;
    logic        reset, flush, stall, in_valid, out_ready;
    logic [63:0] in_data;
    logic [1:0]  rdy_o, vld_o;
    logic [63:0] dat_o [2];
    logic [1:0]  occ_o [2];
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] scnt [2];
    logic [31:0] fcnt [2];
`endif

    int checks = 0;
    int errors = 0;

    // reference model: FIFO of capacity 1 (index 0, SKID=0) or 2 (index 1)
    logic [63:0] mbuf  [2][2];
    int          mcnt  [2];
    logic [63:0] mlast [2];
    bit          mrdy  [2];
    logic [31:0] mstall[2];
    logic [31:0] mflush[2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(64), .SKID(1), .RESET_DATA(RST_D)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(rdy_o[1]), .in_data(in_data),
        .out_valid(vld_o[1]), .out_ready(out_ready), .out_data(dat_o[1]),
        .occupancy(occ_o[1])
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(scnt[1]), .flush_cnt(fcnt[1])
`endif
    );

    pipe_stage_reg #(.WIDTH(64), .SKID(0), .RESET_DATA(RST_D)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(rdy_o[0]), .in_data(in_data),
        .out_valid(vld_o[0]), .out_ready(out_ready), .out_data(dat_o[0]),
        .occupancy(occ_o[0])
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(scnt[0]), .flush_cnt(fcnt[0])
`endif
    );

    typedef struct {
        bit          iv;
        logic [63:0] id;
        bit          ordy;
        bit          stl;
        bit          fl;
        bit          ev;
        logic [63:0] ed;
        logic [1:0]  eocc;
        bit          erdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit iv, logic [63:0] id, bit ordy, bit stl, bit fl,
                                bit ev, logic [63:0] ed, logic [1:0] eocc, bit erdy);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.stl = stl; v.fl = fl;
        v.ev = ev; v.ed = ed; v.eocc = eocc; v.erdy = erdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit iv, input logic [63:0] id, input bit ordy,
                         input bit stl, input bit fl, input bit rst);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        stall     = stl;
        flush     = fl;
        reset     = rst;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mcnt[d]   = 0;
            mlast[d]  = RST_D;
            mstall[d] = '0;
            mflush[d] = '0;
        end
    endtask

    // one clock: check upstream ready, step the model across the edge, check outputs
    task automatic cycle();
        bit acc [2];
        bit del [2];
        #2;
        for (int d = 0; d < 2; d++) begin
            mrdy[d] = (d == 1) ? (mcnt[1] < 2) : ((mcnt[0] == 0) || (out_ready && !stall));
            chk($sformatf("s%0d_in_ready_pre", d), 64'(rdy_o[d]), 64'(mrdy[d]));
            acc[d] = in_valid && mrdy[d];
            del[d] = (mcnt[d] > 0) && out_ready && !stall;
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                mcnt[d]   = 0;
                mlast[d]  = RST_D;
                mstall[d] = '0;
                mflush[d] = '0;
            end else begin
                if ((mcnt[d] > 0) && !(out_ready && !stall)) mstall[d]++;
                if (flush && (mcnt[d] > 0)) mflush[d]++;
                if (flush) begin
                    mcnt[d] = 0;
                end else begin
                    if (del[d]) begin
                        mbuf[d][0] = mbuf[d][1];
                        mcnt[d]--;
                    end
                    if (acc[d]) begin
                        mbuf[d][mcnt[d]] = in_data;
                        mcnt[d]++;
                    end
                end
                if (mcnt[d] > 0) mlast[d] = mbuf[d][0];
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("s%0d_out_valid", d), 64'(vld_o[d]), 64'(mcnt[d] > 0));
            chk($sformatf("s%0d_out_data", d), dat_o[d], mlast[d]);
            chk($sformatf("s%0d_occupancy", d), 64'(occ_o[d]), 64'(mcnt[d]));
`ifdef PIPE_STAGE_PERF_EN
            chk($sformatf("s%0d_stall_cnt", d), 64'(scnt[d]), 64'(mstall[d]));
            chk($sformatf("s%0d_flush_cnt", d), 64'(fcnt[d]), 64'(mflush[d]));
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;

        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d_out_valid", d), 64'(vld_o[d]), 64'h0);
            chk($sformatf("rst%0d_out_data", d), dat_o[d], 64'hDEAD);
            chk($sformatf("rst%0d_occupancy", d), 64'(occ_o[d]), 64'h0);
            chk($sformatf("rst%0d_in_ready", d), 64'(rdy_o[d]), 64'h1);
        end

        // SKID=1 vectors: inputs for one edge, expected outputs after it
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(1, 64'(k), 1, 0, 0, 1, 64'(k), 2'd1, 1));
        tbl.push_back(mk(0, 64'h0,  1, 0, 0, 0, 64'h8,  2'd0, 1));
        tbl.push_back(mk(1, 64'hA,  1, 1, 0, 1, 64'hA,  2'd1, 1));
        tbl.push_back(mk(1, 64'hB,  1, 1, 0, 1, 64'hA,  2'd2, 0));
        tbl.push_back(mk(0, 64'h0,  1, 0, 0, 1, 64'hB,  2'd1, 1));
        tbl.push_back(mk(0, 64'h0,  1, 0, 0, 0, 64'hB,  2'd0, 1));
        tbl.push_back(mk(1, 64'h11, 1, 1, 0, 1, 64'h11, 2'd1, 1));
        tbl.push_back(mk(1, 64'h12, 1, 1, 0, 1, 64'h11, 2'd2, 0));
        tbl.push_back(mk(1, 64'hC,  1, 1, 1, 0, 64'h11, 2'd0, 1));
        tbl.push_back(mk(0, 64'h0,  1, 0, 0, 0, 64'h11, 2'd0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].stl, tbl[i].fl, 1'b0);
            cycle();
            chk($sformatf("vec%0d_out_valid", i), 64'(vld_o[1]), 64'(tbl[i].ev));
            chk($sformatf("vec%0d_out_data", i), dat_o[1], tbl[i].ed);
            chk($sformatf("vec%0d_occupancy", i), 64'(occ_o[1]), 64'(tbl[i].eocc));
            chk($sformatf("vec%0d_in_ready", i), 64'(rdy_o[1]), 64'(tbl[i].erdy));
        end

        // SKID=0: head held with downstream blocked, then replaced on the draining edge
        drive(1, 64'h4, 0, 0, 0, 0);
        cycle();
        chk("s0_busy_data", dat_o[0], 64'h4);
        drive(1, 64'h5, 0, 0, 0, 0);
        #2;
        chk("s0_busy_blocked_ready", 64'(rdy_o[0]), 64'h0);
        out_ready = 1'b1;
        #1;
        chk("s0_busy_drain_ready", 64'(rdy_o[0]), 64'h1);
        cycle();
        chk("s0_replace_data", dat_o[0], 64'h5);
        chk("s0_replace_occ", 64'(occ_o[0]), 64'h1);
        chk("s0_replace_valid", 64'(vld_o[0]), 64'h1);
        drive(0, 64'h0, 1, 0, 0, 0);
        cycle();

        // reset mid-transfer
        drive(1, 64'h99, 0, 0, 0, 0);
        cycle();
        drive(1, 64'h9A, 1, 0, 1, 1);
        cycle();
        chk("mid_reset_data", dat_o[1], 64'hDEAD);
        chk("mid_reset_valid", 64'(vld_o[1]), 64'h0);

`ifdef PIPE_STAGE_PERF_EN
        drive(1, 64'h77, 0, 0, 0, 0);
        cycle();
        for (int k = 0; k < 3; k++) begin
            drive(0, 64'h0, 1, 1, 0, 0);
            cycle();
        end
        drive(0, 64'h0, 1, 0, 1, 0);
        cycle();
        chk("perf_stall_cnt", 64'(scnt[1]), 64'd3);
        chk("perf_flush_cnt", 64'(fcnt[1]), 64'd1);
        drive(0, 64'h0, 0, 0, 0, 1);
        cycle();
        chk("perf_stall_rst", 64'(scnt[1]), 64'd0);
        chk("perf_flush_rst", 64'(fcnt[1]), 64'd0);
`endif

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            drive(($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 3) != 0,
                  ($urandom % 4) == 0, ($urandom % 25) == 0, ($urandom % 80) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the 5-stage core; replaces the fixed per-stage latch registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
- Adds a valid/ready handshake, a 2-entry skid buffer so upstream ready is registered, and a flush input.
- Carries an opaque payload of WIDTH bits. Instantiated once per stage boundary; the payload is the stage's packed struct from pipes.

Parameters:
- WIDTH, 64, payload width in bits (>=1).
- SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single entry (in_ready combinational).
- RESET_DATA, 0, payload value loaded on reset; WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; takes effect on the posedge where it is sampled high.
- flush  in  1  discard all held entries (branch mispredict/exception).
- stall  in  1  hazard hold; downstream treats the stage as not ready.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  block can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  head payload.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).

Behaviour:
- Accept condition: in_valid & in_ready. Deliver condition: out_valid & out_ready & !stall.
- Reset: main and skid valid bits cleared; data regs = RESET_DATA.
  - out_valid=0, out_data=RESET_DATA, occupancy=0, in_ready=1 in the cycle after reset.
- Latency: 1 cycle. Data accepted at edge N is visible on out_data after edge N.
- SKID=1 state machine over (main_v, skid_v):
  - EMPTY(0,0): accept -> BUSY.
  - BUSY(1,0): accept & deliver -> BUSY with main=new; accept only -> FULL (new into skid); deliver only -> EMPTY; neither -> hold.
  - FULL(1,1): deliver -> BUSY with main<=skid; no accept possible.
  - in_ready = !skid_v; it is driven from a register with no combinational path from out_ready/stall.
- SKID=0:
  - in_ready = !main_v | (out_ready & !stall).
  - Simultaneous accept and deliver replaces main in the same edge.
- stall=1 blocks delivery regardless of out_ready. Accept still occurs into any free entry.
- Flush: at the edge it is sampled high, both valid bits are cleared and any concurrent accept is dropped.
  - Data regs keep their values; out_valid=0 and in_ready=1 in the next cycle.
  - Reset has priority over flush. Flush has priority over stall and handshakes.
- The block never drops or duplicates entries. Order is FIFO (skid drains into main before new data).
- out_data is undefined-but-stable while out_valid=0: it holds its last value and does not toggle.
- Reset asserted mid-transfer aborts the transfer and gives the reset state; no partial update.

Optional Feature:
- PIPE_STAGE_PERF_EN.
- When defined, adds outputs stall_cnt (32 bits) and flush_cnt (32 bits):
  - stall_cnt increments each cycle with out_valid & !(out_ready & !stall).
  - flush_cnt increments each cycle flush=1 while occupancy != 0.
  - Both counters saturate at all-ones and clear on reset.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- In package pipes:
  - typedef pipe_occ_t (2-bit occupancy).
  - Localparam PIPE_CNT_W=32.
  - Per-stage payload structs (fetch/decode/execute/memory data types); callers size WIDTH with $bits of these.
- One natural sub-module: pipe_skid_buf. It holds the skid entry and the registered in_ready.
  - Instantiated only when SKID=1 via a generate block.
  - pipe_stage_reg keeps the main entry, flush/stall logic and perf counters.

Test Plan:
- Reset, WIDTH=64, RESET_DATA=64'hDEAD -> out_valid=0, out_data=64'hDEAD, occupancy=0, in_ready=1.
- Stream 0x1..0x8 with out_ready=1, stall=0 -> out_data shows 0x1..0x8 on consecutive cycles, each 1 cycle after accept; occupancy stays 1.
- Stall while streaming:
  - SKID=1: accept 0xA then 0xB with stall=1 -> occupancy=2, in_ready=0 the next cycle. Release stall -> 0xA then 0xB delivered in order, with no drop and no duplicate.
- Flush in FULL with in_valid=1, in_data=0xC -> next cycle out_valid=0, occupancy=0, 0xC never appears.
- SKID=0: BUSY with out_ready=1 plus a new accept 0x5 on the same edge -> main=0x5, occupancy=1, no bubble.
- PIPE_STAGE_PERF_EN defined, 3 stalled cycles with valid head plus 1 flush -> stall_cnt=3, flush_cnt=1; reset -> both 0.
